// File: rtl/scan_cmd_sequencer.sv
// UART command sequencer for part_tester: parses command byte + 16-bit count and drives the
// part's scan/PI/PO/clock/reset pins. Optional echo of accepted commands under CMD_ECHO_EN.
module scan_cmd_sequencer #(
  parameter int NREGS   = 6,
  parameter int NPIS    = 14,
  parameter int NPOS    = 11,
  parameter int CLK_DIV = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  output logic            tx_start,
  output logic [7:0]      tx_data,
  input  logic            tx_ready,
  output logic            part_clk,
  output logic            part_rstn,
  output logic            test_se,
  output logic            test_tm,
  output logic            scan_in,
  input  logic            scan_out,
  output logic [NPIS-1:0] pis_o,
  input  logic [NPOS-1:0] pos_i,
  output logic            busy,
  output logic            cmd_err,
  output logic [3:0]      state_dbg
);

  if (CLK_DIV < 1 || NREGS < 1) begin : g_bad_param
    $error("scan_cmd_sequencer: CLK_DIV and NREGS must be >= 1");
  end

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] CNT_HI    = 4'd1;
  localparam logic [3:0] CNT_LO    = 4'd2;
  localparam logic [3:0] WAIT_DATA = 4'd3;
  localparam logic [3:0] PULSE     = 4'd4;
  localparam logic [3:0] SEND      = 4'd5;
  localparam logic [3:0] WAIT_TX   = 4'd6;
  localparam logic [3:0] EXEC      = 4'd7;
  localparam logic [3:0] FREE      = 4'd8;
  localparam logic [3:0] RST       = 4'd9;

  localparam logic [7:0] CMD_S = 8'h73;
  localparam logic [7:0] CMD_G = 8'h67;
  localparam logic [7:0] CMD_I = 8'h69;
  localparam logic [7:0] CMD_O = 8'h6F;
  localparam logic [7:0] CMD_E = 8'h65;
  localparam logic [7:0] CMD_R = 8'h72;
  localparam logic [7:0] CMD_F = 8'h66;
  localparam logic [7:0] CMD_P = 8'h70;

  localparam int PW = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [PW-1:0] PC_HI  = PW'(CLK_DIV);
  localparam logic [PW-1:0] PC_END = PW'(2 * CLK_DIV - 1);

  logic [3:0]    state;
  logic [7:0]    cmd;
  logic [15:0]   cnt;
  logic [15:0]   idx;
  logic [PW-1:0] pc;
  logic          stop_req;
  logic          echo;
  logic          pulse_end;
  logic          iter_done;
  logic [3:0]    iter_state;
  logic [15:0]   idx_n;
  logic          pos_bit;
  logic [7:0]    send_char;
  logic          is_cmd;

  function automatic logic [3:0] cmd_target(input logic [7:0] c);
    if (c == CMD_R)      return RST;
    else if (c == CMD_F) return FREE;
    else                 return CNT_HI;
  endfunction

  assign is_cmd = (rx_data == CMD_S) || (rx_data == CMD_G) || (rx_data == CMD_I) ||
                  (rx_data == CMD_O) || (rx_data == CMD_E) || (rx_data == CMD_R) ||
                  (rx_data == CMD_F);

  assign pulse_end = (pc == PC_END);
  assign idx_n     = (state == CNT_LO) ? 16'd0 : idx + 16'd1;
  assign send_char = {7'b0011000, (cmd == CMD_G) ? scan_out : pos_bit};

  always_comb begin
    pos_bit = 1'b0;
    for (int k = 0; k < NPOS; k++)
      if (idx_n == 16'(k)) pos_bit = pos_i[k];
  end

  always_comb begin
    iter_state = EXEC;
    if (cmd == CMD_S || cmd == CMD_I)      iter_state = WAIT_DATA;
    else if (cmd == CMD_G || cmd == CMD_O) iter_state = SEND;
  end

  // One loop iteration retires here; the down-counter exits on its 1->0 step.
  always_comb begin
    iter_done = 1'b0;
    case (state)
      WAIT_DATA:   iter_done = rx_valid && (cmd == CMD_I);
      PULSE, EXEC: iter_done = pulse_end;
      WAIT_TX:     iter_done = tx_ready && !echo && (cmd == CMD_O);
      default:     iter_done = 1'b0;
    endcase
  end

  // TX handshake: tx_start rises with tx_data loaded and holds until tx_ready is seen low;
  // WAIT_TX then waits for tx_ready to return high before the byte counts as sent.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cmd      <= 8'h00;
      cnt      <= 16'd0;
      idx      <= 16'd0;
      pc       <= '0;
      part_clk <= 1'b0;
      test_se  <= 1'b0;
      scan_in  <= 1'b0;
      pis_o    <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      cmd_err  <= 1'b0;
      stop_req <= 1'b0;
      echo     <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      case (state)
        IDLE: if (rx_valid) begin
          if (is_cmd) begin
            cmd <= rx_data;
`ifdef CMD_ECHO_EN
            tx_data  <= rx_data;
            tx_start <= 1'b1;
            echo     <= 1'b1;
            state    <= SEND;
`else
            state <= cmd_target(rx_data);
`endif
          end else begin
            cmd_err <= 1'b1;
          end
        end
        CNT_HI: if (rx_valid) begin
          cnt[15:8] <= rx_data;
          idx       <= 16'd0;
          state     <= CNT_LO;
        end
        CNT_LO: if (rx_valid) begin
          if ({cnt[15:8], rx_data} == 16'd0) begin
            state <= IDLE;
          end else begin
            cnt     <= {cnt[15:8], rx_data};
            test_se <= (cmd == CMD_S) || (cmd == CMD_G);
            state   <= iter_state;
            if (iter_state == SEND) begin
              tx_data  <= send_char;
              tx_start <= 1'b1;
            end
          end
        end
        WAIT_DATA: if (rx_valid) begin
          if (cmd == CMD_S) begin
            scan_in <= rx_data[0];
            state   <= PULSE;
          end else begin
            for (int k = 0; k < NPIS; k++)
              if (idx == 16'(k)) pis_o[k] <= rx_data[0];
          end
        end
        // pc=0 raises part_clk, pc=CLK_DIV drops it, the pulse retires at pc=2*CLK_DIV-1.
        PULSE, EXEC, FREE: begin
          pc <= pulse_end ? '0 : pc + 1'b1;
          if (pc == '0)   part_clk <= 1'b1;
          if (pc == PC_HI) part_clk <= 1'b0;
          if (state == FREE) begin
            if (rx_valid && rx_data == CMD_P) stop_req <= 1'b1;
            if (pulse_end && (stop_req || (rx_valid && rx_data == CMD_P))) begin
              stop_req <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        SEND: if (!tx_ready) begin
          tx_start <= 1'b0;
          state    <= WAIT_TX;
        end
        WAIT_TX: if (tx_ready) begin
          if (echo) begin
            echo  <= 1'b0;
            state <= cmd_target(cmd);
          end else if (cmd == CMD_G) begin
            state <= PULSE;
          end
        end
        RST: begin
          pc <= pulse_end ? '0 : pc + 1'b1;
          if (pulse_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (iter_done) begin
        cnt <= cnt - 16'd1;
        idx <= idx + 16'd1;
        if (cnt == 16'd1) begin
          state   <= IDLE;
          test_se <= 1'b0;
        end else begin
          state <= iter_state;
          if (iter_state == SEND) begin
            tx_data  <= send_char;
            tx_start <= 1'b1;
          end
        end
      end
    end
  end

  assign part_rstn = (state != RST);
  assign test_tm   = (state != FREE) && (state != EXEC);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_scan_cmd_sequencer.sv
// Randomized scoreboard bench for scan_cmd_sequencer with a 6-register scan chain device model.
module tb_scan_cmd_sequencer;
  localparam int NREGS   = 6;
  localparam int NPIS    = 14;
  localparam int NPOS    = 11;
  localparam int CLK_DIV = 4;

  localparam logic [7:0] C_S = 8'h73, C_G = 8'h67, C_I = 8'h69, C_O = 8'h6F;
  localparam logic [7:0] C_E = 8'h65, C_R = 8'h72, C_F = 8'h66, C_P = 8'h70, C_X = 8'h78;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            rx_valid = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_ready = 1'b1;
  logic            part_clk;
  logic            part_rstn;
  logic            test_se;
  logic            test_tm;
  logic            scan_in;
  logic            scan_out;
  logic [NPIS-1:0] pis_o;
  logic [NPOS-1:0] pos_i = '0;
  logic            busy;
  logic            cmd_err;
  logic [3:0]      state_dbg;

  scan_cmd_sequencer #(.NREGS(NREGS), .NPIS(NPIS), .NPOS(NPOS), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_ready(tx_ready),
    .part_clk(part_clk), .part_rstn(part_rstn), .test_se(test_se), .test_tm(test_tm),
    .scan_in(scan_in), .scan_out(scan_out), .pis_o(pis_o), .pos_i(pos_i),
    .busy(busy), .cmd_err(cmd_err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  // Scan chain of the part under test, clocked by part_clk.
  logic [NREGS-1:0] chain = '0;
  always @(posedge part_clk) chain <= {chain[NREGS-2:0], scan_in};
  assign scan_out = chain[NREGS-1];

  // ---------------- scoreboard state ----------------
  logic [7:0]      exp_q[$];
  logic            exp_scan_q[$];
  int              n_tests = 0;
  int              n_fail = 0;
  int              pulse_cnt = 0;
  int              rst_low_cnt = 0;
  logic            exp_se = 1'b0;
  logic            exp_tm = 1'b1;
  logic            uart_mute = 1'b0;
  logic [NREGS-1:0] m_chain = '0;
  logic [NPIS-1:0] m_pis = '0;
  logic            last_si = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // UART transmitter model: accepts tx_start, goes busy for a few cycles, checks the byte.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start && tx_ready && !uart_mute) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tx_unexpected: got %0h expected none", tx_data);
        end else begin
          check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        end
        tx_ready = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        tx_ready = 1'b1;
      end
    end
  end

  // Pin monitor: counts part_clk rises and reset-low cycles, checks pins at each rise.
  initial begin
    logic pclk_q;
    pclk_q = 1'b0;
    forever begin
      @(negedge clk);
      if (part_clk && !pclk_q) begin
        pulse_cnt++;
        check("se_at_rise", {31'd0, test_se}, {31'd0, exp_se});
        check("tm_at_rise", {31'd0, test_tm}, {31'd0, exp_tm});
        if (exp_se) begin
          if (exp_scan_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scan_rise_unexpected: got scan_in %0b expected no pulse", scan_in);
          end else begin
            check("scan_in_at_rise", {31'd0, scan_in}, {31'd0, exp_scan_q.pop_front()});
          end
        end
      end
      pclk_q = part_clk;
      if (!part_rstn) rst_low_cnt++;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [15:0] n);
    send_byte(c, $urandom_range(0, 2));
    send_byte(n[15:8], $urandom_range(0, 2));
    send_byte(n[7:0], 0);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  // bits[i] is the i-th data byte's LSB.
  task automatic run_s(input int n, input logic [31:0] bits);
    int base;
    base = pulse_cnt;
    exp_se = 1'b1;
    exp_tm = 1'b1;
    send_cmd(C_S, 16'(n));
    for (int i = 0; i < n; i++) begin
      exp_scan_q.push_back(bits[i]);
      m_chain = {m_chain[NREGS-2:0], bits[i]};
      last_si = bits[i];
      send_byte({7'($urandom), bits[i]}, 2 * CLK_DIV + $urandom_range(0, 3));
    end
    wait_idle("s");
    check("s_pulses", pulse_cnt - base, n);
    check("s_se_after", {31'd0, test_se}, 32'd0);
  endtask

  task automatic run_g(input int n);
    int base;
    base = pulse_cnt;
    exp_se = 1'b1;
    exp_tm = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(m_chain[NREGS-1] ? 8'h31 : 8'h30);
      exp_scan_q.push_back(last_si);
      m_chain = {m_chain[NREGS-2:0], last_si};
    end
    send_cmd(C_G, 16'(n));
    wait_idle("g");
    check("g_pulses", pulse_cnt - base, n);
    check("g_txq_drained", exp_q.size(), 0);
  endtask

  task automatic run_i(input int n, input logic [31:0] bits);
    int base;
    base = pulse_cnt;
    send_cmd(C_I, 16'(n));
    for (int k = 0; k < n; k++) begin
      if (k < NPIS) m_pis[k] = bits[k];
      send_byte({7'($urandom), bits[k]}, $urandom_range(0, 2));
    end
    wait_idle("i");
    check("i_pis", {18'd0, pis_o}, {18'd0, m_pis});
    check("i_no_pulses", pulse_cnt - base, 0);
  endtask

  task automatic run_o(input int n);
    int base;
    base = pulse_cnt;
    pos_i = NPOS'($urandom);
    for (int k = 0; k < n; k++)
      exp_q.push_back((k < NPOS && pos_i[k]) ? 8'h31 : 8'h30);
    send_cmd(C_O, 16'(n));
    wait_idle("o");
    check("o_no_pulses", pulse_cnt - base, 0);
    check("o_txq_drained", exp_q.size(), 0);
  endtask

  task automatic run_e(input int n);
    int base;
    base = pulse_cnt;
    exp_se = 1'b0;
    exp_tm = 1'b0;
    send_cmd(C_E, 16'(n));
    if (n == 0) check("e0_idle_next_cycle", {31'd0, busy}, 32'd0);
    wait_idle("e");
    check("e_pulses", pulse_cnt - base, n);
    for (int i = 0; i < n; i++) m_chain = {m_chain[NREGS-2:0], last_si};
    exp_tm = 1'b1;
  endtask

  task automatic run_r();
    int base;
    base = rst_low_cnt;
    send_byte(C_R, 0);
    wait_idle("r");
    check("r_low_cycles", rst_low_cnt - base, 2 * CLK_DIV);
    check("r_pis_kept", {18'd0, pis_o}, {18'd0, m_pis});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base, t, d;
    repeat (3) @(negedge clk);
    check("rst_pins_active", {24'd0, tx_start, part_clk, part_rstn, test_se, test_tm, scan_in, busy, cmd_err},
          32'b0010_1000);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_pins", {24'd0, tx_start, part_clk, part_rstn, test_se, test_tm, scan_in, busy, cmd_err},
          32'b0010_1000);
    check("rst_pis", {18'd0, pis_o}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);

    // Free-running clock, stopped with 'p'.
    base = pulse_cnt;
    exp_se = 1'b0;
    exp_tm = 1'b0;
    send_byte(C_F, 0);
    t = 0;
    while (pulse_cnt - base < 10 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("free_reached_10", {31'd0, pulse_cnt - base >= 10}, 32'd1);
    send_byte(C_P, 0);
    wait_idle("free");
    d = pulse_cnt - base;
    check("free_pulses_10_or_11", {31'd0, (d == 10 || d == 11)}, 32'd1);
    check("free_clk_low", {31'd0, part_clk}, 32'd0);
    exp_tm = 1'b1;

    // Shift "110010" then read it back through the chain.
    run_s(6, 32'b010011);
    run_g(6);

    run_i(16, 32'hFFFF);
    check("i_all_ones", {18'd0, pis_o}, 32'h3FFF);
    run_e(4);
    run_e(0);

    send_byte(C_X, 0);
    check("x_cmd_err", {31'd0, cmd_err}, 32'd1);
    @(negedge clk);
    check("x_cmd_err_pulse", {31'd0, cmd_err}, 32'd0);
    send_byte(C_P, 0);
    check("p_idle_cmd_err", {31'd0, cmd_err}, 32'd1);
    check("p_idle_stays", {31'd0, busy}, 32'd0);

    run_r();

    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 5))
        0: run_s($urandom_range(1, 8), $urandom);
        1: run_g($urandom_range(1, 8));
        2: run_i($urandom_range(1, 18), $urandom);
        3: run_o($urandom_range(1, 14));
        4: run_e($urandom_range(0, 5));
        default: run_r();
      endcase
    end

    // Reset in the middle of a 'g' read while tx_start is held.
    uart_mute = 1'b1;
    send_cmd(C_G, 16'd2);
    t = 0;
    while (!tx_start && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("midg_tx_start", {31'd0, tx_start}, 32'd1);
    rstn = 1'b0;
    #1;
    check("midg_tx_drop", {31'd0, tx_start}, 32'd0);
    check("midg_idle", {31'd0, busy}, 32'd0);
    check("midg_pis_clear", {18'd0, pis_o}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    uart_mute = 1'b0;
    m_pis = '0;
    last_si = 1'b0;
    run_s(3, $urandom);
    run_g(4);

    repeat (20) @(negedge clk);
    check("final_tx_q_empty", exp_q.size(), 0);
    check("final_scan_q_empty", exp_scan_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
